// File: rtl/debounce_pkg.sv
// Shared types and constants for the debounce/synchroniser stage.
// Glitch counting is enabled by defining DEBOUNCE_GLITCH_CNT_EN.
package debounce_pkg;

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        RISE_CHK = 2'd1,
        HIGH     = 2'd2,
        FALL_CHK = 2'd3
    } state_e;

    localparam int GLITCH_CNT_W = 8;

    // Saturating increment: a full counter stays full.
    function automatic logic [GLITCH_CNT_W-1:0] sat_inc(
        input logic [GLITCH_CNT_W-1:0] v
    );
        return (v == {GLITCH_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for a single asynchronous bit.
// Reusable wherever an async level must enter the clk domain.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ff_q <= '0;
        end else begin
            ff_q <= {ff_q[STAGES-2:0], d};
        end
    end

    assign q = ff_q[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronise and debounce a noisy async input; emit rise/fall pulses.
// Define DEBOUNCE_GLITCH_CNT_EN to count aborted transitions.
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    d_raw,
    output logic                    d_clean,
    output logic                    rise,
    output logic                    fall,
    output logic [GLITCH_CNT_W-1:0] glitch_cnt
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             clean_q;
    logic             rise_q;
    logic             fall_q;

    sync_chain #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (d_raw),
        .q    (s)
    );

    // Entering a check state loads 1: the sample that triggered it counts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LOW;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            unique case (state_q)
                LOW: begin
                    if (s) begin
                        state_q <= RISE_CHK;
                        cnt_q   <= CNT_ONE;
                    end
                end
                RISE_CHK: begin
                    if (!s) begin
                        state_q <= LOW;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= HIGH;
                        cnt_q   <= '0;
                        clean_q <= 1'b1;
                        rise_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                HIGH: begin
                    if (!s) begin
                        state_q <= FALL_CHK;
                        cnt_q   <= CNT_ONE;
                    end
                end
                FALL_CHK: begin
                    if (s) begin
                        state_q <= HIGH;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= LOW;
                        cnt_q   <= '0;
                        clean_q <= 1'b0;
                        fall_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
            endcase
        end
    end

    assign d_clean = clean_q;
    assign rise    = rise_q;
    assign fall    = fall_q;

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic                    glitch_evt;
    logic [GLITCH_CNT_W-1:0] glitch_d;
    logic [GLITCH_CNT_W-1:0] glitch_q;

    assign glitch_evt = ((state_q == RISE_CHK) && !s) ||
                        ((state_q == FALL_CHK) &&  s);
    assign glitch_d   = glitch_evt ? sat_inc(glitch_q) : glitch_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            glitch_q <= '0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign glitch_cnt = glitch_q;
`else
    assign glitch_cnt = '0;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Scoreboard bench for debounce_sync: a run-length reference model
// pushes expected outputs each edge; a checker pops them 1 ns later.
module tb_debounce_sync;

    localparam int SYNC = 2;
    localparam int STAB = 4;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    localparam int GC_SAT = 255;
`else
    localparam int GC_SAT = 0;
`endif

    typedef struct packed {
        logic       c;
        logic       r;
        logic       f;
        logic [7:0] g;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       d_raw;
    logic       d_clean;
    logic       rise;
    logic       fall;
    logic [7:0] glitch_cnt;

    int n_cmp;
    int n_err;
    int n_rise;
    int n_fall;
    exp_t sb_q[$];

    debounce_sync #(
        .SYNC_STAGES  (SYNC),
        .STABLE_CYCLES(STAB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .d_raw     (d_raw),
        .d_clean   (d_clean),
        .rise      (rise),
        .fall      (fall),
        .glitch_cnt(glitch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Reference: d_clean flips once STAB consecutive synchronised
    // samples disagree with it; a run broken early is a glitch.
    logic [SYNC-1:0] m_sh;
    logic            m_c;
    int              m_run;
    int              m_g;

    initial begin
        logic s_old;
        exp_t e;
        m_sh  = '0;
        m_c   = 1'b0;
        m_run = 0;
        m_g   = 0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_sh  = '0;
                m_c   = 1'b0;
                m_run = 0;
                m_g   = 0;
            end else begin
                s_old = m_sh[SYNC-1];
                m_sh  = {m_sh[SYNC-2:0], d_raw};
                e     = '0;
                if (s_old != m_c) begin
                    m_run++;
                    if (m_run == STAB) begin
                        m_c   = ~m_c;
                        e.r   = m_c;
                        e.f   = ~m_c;
                        m_run = 0;
                    end
                end else begin
`ifdef DEBOUNCE_GLITCH_CNT_EN
                    if (m_run > 0 && m_g < 255) m_g++;
`endif
                    m_run = 0;
                end
                e.c = m_c;
                e.g = 8'(m_g);
                sb_q.push_back(e);
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rise) n_rise++;
            if (fall) n_fall++;
            if (reset) begin
                chk("rst_clean", d_clean, 0);
                chk("rst_rise", rise, 0);
                chk("rst_fall", fall, 0);
                chk("rst_gc", glitch_cnt, 0);
            end else if (sb_q.size() == 0) begin
                chk("sb_empty", 0, 1);
            end else begin
                e = sb_q.pop_front();
                chk("d_clean", d_clean, e.c);
                chk("rise", rise, e.r);
                chk("fall", fall, e.f);
                chk("glitch_cnt", glitch_cnt, e.g);
            end
        end
    end

    task automatic wait_clean(input logic v, output int n);
        n = 0;
        while (n < 50) begin
            @(posedge clk);
            n++;
            #1;
            if (d_clean == v) return;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_clean"}, d_clean, 0);
        chk({tag, "_rise"}, rise, 0);
        chk({tag, "_fall"}, fall, 0);
        chk({tag, "_gc"}, glitch_cnt, 0);
    endtask

    initial begin
        int n;
        int br;
        int bf;
        n_cmp  = 0;
        n_err  = 0;
        n_rise = 0;
        n_fall = 0;
        reset  = 1'b1;
        d_raw  = 1'b1;

        // Reset with d_raw held high
        repeat (3) @(negedge clk);
        chk_zero("in_rst");
        br = n_rise;
        bf = n_fall;
        reset = 1'b0;
        wait_clean(1'b1, n);
        chk("rst_rel_lat", n, 6);
        repeat (2) @(negedge clk);
        chk("rst_rel_rises", n_rise - br, 1);
        chk("rst_rel_falls", n_fall - bf, 0);

        // Clean fall, then clean rise/fall with 100 ns hold
        d_raw = 1'b0;
        wait_clean(1'b0, n);
        chk("fall0_lat", n, 6);
        @(negedge clk);
        br = n_rise;
        bf = n_fall;
        d_raw = 1'b1;
        wait_clean(1'b1, n);
        chk("rise_lat", n, 6);
        repeat (5) @(negedge clk);
        d_raw = 1'b0;
        wait_clean(1'b0, n);
        chk("fall_lat", n, 6);
        repeat (2) @(negedge clk);
        chk("clean_rises", n_rise - br, 1);
        chk("clean_falls", n_fall - bf, 1);

        // Bounce 1,0,1,0 then settle high
        br = n_rise;
        bf = n_fall;
        for (int i = 0; i < 4; i++) begin
            d_raw = (i % 2 == 0);
            @(negedge clk);
        end
        d_raw = 1'b1;
        wait_clean(1'b1, n);
        chk("bounce_lat", n, 6);
        repeat (2) @(negedge clk);
        chk("bounce_rises", n_rise - br, 1);
        chk("bounce_falls", n_fall - bf, 0);
        d_raw = 1'b0;
        wait_clean(1'b0, n);
        @(negedge clk);

        // Short 20 ns pulse
        br = n_rise;
        bf = n_fall;
        d_raw = 1'b1;
        repeat (2) @(negedge clk);
        d_raw = 1'b0;
        repeat (10) @(negedge clk);
        chk("short_clean", d_clean, 0);
        chk("short_rises", n_rise - br, 0);
        chk("short_falls", n_fall - bf, 0);

        // Reset two cycles into RISE_CHK
        br = n_rise;
        bf = n_fall;
        d_raw = 1'b1;
        repeat (4) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk_zero("mid_rst");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_clean(1'b1, n);
        chk("mid_rst_lat", n, 6);
        repeat (2) @(negedge clk);
        chk("mid_rst_rises", n_rise - br, 1);
        chk("mid_rst_falls", n_fall - bf, 0);

        // 300 single-cycle glitches
        d_raw = 1'b0;
        wait_clean(1'b0, n);
        @(negedge clk);
        for (int i = 0; i < 300; i++) begin
            d_raw = 1'b1;
            @(negedge clk);
            d_raw = 1'b0;
            @(negedge clk);
        end
        repeat (6) @(negedge clk);
        chk("sat_gc", glitch_cnt, GC_SAT);
        chk("sat_clean", d_clean, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
